// File: rtl/frame_grabber_pkg.sv
// Shared types and constants for the frame grabber: FSM encoding, source-select
// codes, start-of-frame defaults and the decimation shift helper.
package frame_grabber_pkg;

   localparam int COORD_W     = 13;
   localparam int FRAME_CNT_W = 16;

   localparam int SOF_X_DEF = 143;
   localparam int SOF_Y_DEF = 34;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SKIP    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_RED   = 2'd0,
      MODE_GREEN = 2'd1,
      MODE_BLUE  = 2'd2,
      MODE_LUMA  = 2'd3
   } mode_t;

   // DECIM is restricted to 1, 2 or 4, so the divide reduces to a shift.
   function automatic int decim_shift(input int decim);
      if (decim >= 4) return 2;
      else if (decim >= 2) return 1;
      else return 0;
   endfunction

endpackage

// File: rtl/grab_pixel_path.sv
// Window test, subsampling, source select and registered memory-write port.
// 'last' flags a qualifying pixel that lands on the final buffer address.
module grab_pixel_path
   import frame_grabber_pkg::*;
#(
   parameter int PIX_W   = 10,
   parameter int H_START = 144,
   parameter int V_START = 35,
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int DECIM   = 1,
   parameter int ADDR_W  = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   red,
   input  logic [PIX_W-1:0]   green,
   input  logic [PIX_W-1:0]   blue,
   input  logic [12:0]        x,
   input  logic [12:0]        y,
   input  logic               valid,
   input  logic               capture,
   input  logic [1:0]         mode,
   output logic               last,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [PIX_W-1:0]   mem_data,
   output logic               mem_we
);

   localparam int DSH       = decim_shift(DECIM);
   localparam int COLS      = H_RES / DECIM;
   localparam int ROWS      = V_RES / DECIM;
   localparam int PRODUCT_W = 2 * COORD_W;

   localparam logic [COORD_W-1:0]   X_LO     = COORD_W'(H_START);
   localparam logic [COORD_W-1:0]   X_HI     = COORD_W'(H_START + H_RES);
   localparam logic [COORD_W-1:0]   Y_LO     = COORD_W'(V_START);
   localparam logic [COORD_W-1:0]   Y_HI     = COORD_W'(V_START + V_RES);
   localparam logic [COORD_W-1:0]   SUB_MASK = COORD_W'(DECIM - 1);
   localparam logic [PRODUCT_W-1:0] COLS_W   = PRODUCT_W'(COLS);
   localparam logic [PRODUCT_W-1:0] LAST_LIN = PRODUCT_W'(COLS * ROWS - 1);

   logic [COORD_W-1:0]   dx;
   logic [COORD_W-1:0]   dy;
   logic                 in_win;
   logic                 on_grid;
   logic                 store;
   logic [PRODUCT_W-1:0] lin;
   logic [PIX_W+1:0]     luma_sum;
   logic [PIX_W-1:0]     pix_sel;

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [PIX_W-1:0]  data_d, data_q;
   logic              we_d, we_q;

   always_comb begin
      dx      = x - X_LO;
      dy      = y - Y_LO;
      in_win  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
      on_grid = ((dx & SUB_MASK) == '0) && ((dy & SUB_MASK) == '0);
      store   = capture && valid && in_win && on_grid;
      lin     = PRODUCT_W'(dy >> DSH) * COLS_W + PRODUCT_W'(dx >> DSH);
      last    = store && (lin == LAST_LIN);
   end

   // Two extra bits hold 4*max, so the shifted luma always fits PIX_W.
   always_comb begin
      luma_sum = {2'b00, red} + {1'b0, green, 1'b0} + {2'b00, blue};
      pix_sel  = '0;
      case (mode_t'(mode))
         MODE_RED:   pix_sel = red;
         MODE_GREEN: pix_sel = green;
         MODE_BLUE:  pix_sel = blue;
         MODE_LUMA:  pix_sel = luma_sum[PIX_W+1:2];
         default:    pix_sel = red;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      we_d   = store;
      if (store) begin
         addr_d = lin[ADDR_W-1:0];
         data_d = pix_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         we_q   <= we_d;
      end
   end

   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign mem_we   = we_q;

endmodule

// File: rtl/frame_grabber.sv
// Single-frame grabber: after arm, skip a number of frames, then store one
// subsampled window of the selected channel or luma into an external buffer.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for iArm; mode latched on arm
//   ST_SKIP    | counting start-of-frame markers until SKIP_FRAMES reached
//   ST_CAPTURE | storing window pixels; camera held via oStopCapture
//   ST_DONE    | single-cycle completion pulse, then back to idle
module frame_grabber
   import frame_grabber_pkg::*;
#(
   parameter int PIX_W       = 10,
   parameter int H_START     = 144,
   parameter int V_START     = 35,
   parameter int H_RES       = 160,
   parameter int V_RES       = 120,
   parameter int DECIM       = 1,
   parameter int SKIP_FRAMES = 300,
   parameter int SOF_X       = SOF_X_DEF,
   parameter int SOF_Y       = SOF_Y_DEF,
   parameter int ADDR_W      = 15
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [PIX_W-1:0]   iRed,
   input  logic [PIX_W-1:0]   iGreen,
   input  logic [PIX_W-1:0]   iBlue,
   input  logic [12:0]        iX,
   input  logic [12:0]        iY,
   input  logic               iValid,
   input  logic               iArm,
   input  logic [1:0]         iMode,
   output logic [ADDR_W-1:0]  oMemAddr,
   output logic [PIX_W-1:0]   oMemData,
   output logic               oMemWE,
   output logic               oBusy,
   output logic               oStopCapture,
   output logic               oDone
);

   localparam logic [COORD_W-1:0]     SOF_XC      = COORD_W'(SOF_X);
   localparam logic [COORD_W-1:0]     SOF_YC      = COORD_W'(SOF_Y);
   localparam logic [FRAME_CNT_W-1:0] SKIP_TARGET = FRAME_CNT_W'(SKIP_FRAMES);

   state_t                 state_d, state_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
   logic [1:0]             mode_d, mode_q;
   logic [FRAME_CNT_W-1:0] frame_inc;
   logic                   sof;
   logic                   last_px;
   logic                   capture;

   assign sof     = iValid && (iX == SOF_XC) && (iY == SOF_YC);
   assign capture = (state_q == ST_CAPTURE);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         mode_q      <= 2'd0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         mode_q      <= mode_d;
      end
   end

   // Completion by last write wins over a coincident SOF; both lead to DONE.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      mode_d      = mode_q;
      frame_inc   = frame_cnt_q + 16'd1;
      case (state_q)
         ST_IDLE: begin
            if (iArm) begin
               state_d     = ST_SKIP;
               mode_d      = iMode;
               frame_cnt_d = '0;
            end
         end
         ST_SKIP: begin
            if (sof) begin
               frame_cnt_d = frame_inc;
               if (frame_inc >= SKIP_TARGET) state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (last_px || sof) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      oBusy        = 1'b0;
      oStopCapture = 1'b0;
      oDone        = 1'b0;
      case (state_q)
         ST_IDLE:    ;
         ST_SKIP:    oBusy = 1'b1;
         ST_CAPTURE: begin
            oBusy        = 1'b1;
            oStopCapture = 1'b1;
         end
         ST_DONE: begin
            oBusy = 1'b1;
            oDone = 1'b1;
         end
         default:    ;
      endcase
   end

   grab_pixel_path #(
      .PIX_W   (PIX_W),
      .H_START (H_START),
      .V_START (V_START),
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .DECIM   (DECIM),
      .ADDR_W  (ADDR_W)
   ) u_path (
      .clk      (iCLK),
      .rst      (iRST),
      .red      (iRed),
      .green    (iGreen),
      .blue     (iBlue),
      .x        (iX),
      .y        (iY),
      .valid    (iValid),
      .capture  (capture),
      .mode     (mode_q),
      .last     (last_px),
      .mem_addr (oMemAddr),
      .mem_data (oMemData),
      .mem_we   (oMemWE)
   );

endmodule

// File: tb/tb_frame_grabber.sv
// Scoreboard bench for frame_grabber on a shrunken 16x12 raster with a
// subsampled 8x6 window; writes are checked by a negedge monitor.
module tb_frame_grabber;

   localparam int PIX_W = 10;
   localparam int HS    = 4;
   localparam int VS    = 3;
   localparam int HR    = 8;
   localparam int VR    = 6;
   localparam int DEC   = 2;
   localparam int SKIP  = 2;
   localparam int SX    = 3;
   localparam int SY    = 2;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [PIX_W-1:0] r, g, b;
   logic [12:0]      x, y;
   logic             valid, arm;
   logic [1:0]       mode;
   logic [AW-1:0]    oMemAddr;
   logic [PIX_W-1:0] oMemData;
   logic             oMemWE, oBusy, oStopCapture, oDone;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [PIX_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  errors = 0;
   int  checks = 0;
   int  wr_seen = 0;
   int  done_seen = 0;
   int  w0, d0;

   frame_grabber #(
      .PIX_W(PIX_W), .H_START(HS), .V_START(VS), .H_RES(HR), .V_RES(VR),
      .DECIM(DEC), .SKIP_FRAMES(SKIP), .SOF_X(SX), .SOF_Y(SY), .ADDR_W(AW)
   ) dut (
      .iCLK(clk), .iRST(rst), .iRed(r), .iGreen(g), .iBlue(b), .iX(x), .iY(y),
      .iValid(valid), .iArm(arm), .iMode(mode),
      .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemWE(oMemWE),
      .oBusy(oBusy), .oStopCapture(oStopCapture), .oDone(oDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input int a, input int d);
      wr_t en;
      en.addr = AW'(a);
      en.data = PIX_W'(d);
      exp_q.push_back(en);
   endtask

   // Inputs change 1 time unit after a rising edge; returns 1 unit after the next.
   task automatic pix(input int px, input int py, input logic v,
                      input logic [PIX_W-1:0] rr, input logic [PIX_W-1:0] gg,
                      input logic [PIX_W-1:0] bb);
      x = 13'(px);
      y = 13'(py);
      valid = v;
      r = rr;
      g = gg;
      b = bb;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) pix(0, 0, 1'b0, 10'h0, 10'h0, 10'h0);
   endtask

   task automatic sof();
      pix(SX, SY, 1'b1, 10'h0, 10'h0, 10'h0);
   endtask

   task automatic raster(input bit cap);
      logic [PIX_W-1:0] gv;
      for (int yy = 0; yy < 12; yy++) begin
         for (int xx = 0; xx < 16; xx++) begin
            gv = PIX_W'((xx * 37 + yy * 11) & 1023);
            if (cap && xx >= HS && xx < HS + HR && yy >= VS && yy < VS + VR &&
                (xx - HS) % DEC == 0 && (yy - VS) % DEC == 0)
               push(((yy - VS) / DEC) * (HR / DEC) + (xx - HS) / DEC, int'(gv));
            pix(xx, yy, 1'b1, ~gv, gv, 10'h155);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (oDone) done_seen++;
         if (oMemWE) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected",
                        oMemAddr, oMemData);
            end else begin
               mon_e = exp_q.pop_front();
               check("write_addr", 32'(oMemAddr), 32'(mon_e.addr));
               check("write_data", 32'(oMemData), 32'(mon_e.data));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; arm = 1'b0; mode = 2'd0; valid = 1'b0;
      x = '0; y = '0; r = '0; g = '0; b = '0;
      #2;
      check("rst_we",   32'(oMemWE), 0);
      check("rst_addr", 32'(oMemAddr), 0);
      check("rst_data", 32'(oMemData), 0);
      check("rst_busy", 32'(oBusy), 0);
      check("rst_stop", 32'(oStopCapture), 0);
      check("rst_done", 32'(oDone), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      check("idle_busy", 32'(oBusy), 0);

      // Capture 1: red, SOF-terminated; an arm in SKIP must not change the mode.
      arm = 1'b1; mode = 2'd0; idle(1); arm = 1'b0;
      check("busy_after_arm", 32'(oBusy), 1);
      check("stop_in_skip", 32'(oStopCapture), 0);
      arm = 1'b1; mode = 2'd3; sof(); arm = 1'b0;
      check("skip_after_sof1", 32'(oStopCapture), 0);
      pix(4, 3, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
      sof();
      check("capture_at_sof2", 32'(oStopCapture), 1);
      push(0, 'h155); pix(4, 3, 1'b1, 10'h155, 10'h0F0, 10'h00F);
      pix(12, 3, 1'b1, 10'h011, 10'h0, 10'h0);
      pix(7, 5, 1'b1, 10'h022, 10'h0, 10'h0);
      push(6, 'h0AA); pix(8, 5, 1'b1, 10'h0AA, 10'h003, 10'h003);
      pix(4, 9, 1'b1, 10'h033, 10'h0, 10'h0);
      pix(6, 3, 1'b0, 10'h044, 10'h0, 10'h0);
      pix(3, 3, 1'b1, 10'h055, 10'h0, 10'h0);
      sof();
      check("done_on_sof", 32'(oDone), 1);
      check("stop_in_done", 32'(oStopCapture), 0);
      idle(1);
      check("done_one_cycle", 32'(oDone), 0);
      check("idle_after_done", 32'(oBusy), 0);

      // Capture 2: luma.
      arm = 1'b1; mode = 2'd3; idle(1); arm = 1'b0;
      sof(); sof();
      push(0, 'h3FF); pix(4, 3, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
      push(1, 'h002); pix(6, 3, 1'b1, 10'h004, 10'h002, 10'h000);
      push(3, 'h080); pix(10, 3, 1'b1, 10'h100, 10'h080, 10'h001);
      sof();
      idle(1);

      // Capture 3: green over full rasters, completes on the last address.
      arm = 1'b1; mode = 2'd1; idle(1); arm = 1'b0;
      w0 = wr_seen; d0 = done_seen;
      raster(1'b0);
      raster(1'b1);
      check("raster_writes", 32'(wr_seen - w0), 12);
      check("raster_done_pulses", 32'(done_seen - d0), 1);
      check("raster_stop_after", 32'(oStopCapture), 0);
      check("raster_idle_after", 32'(oBusy), 0);
      w0 = wr_seen;
      raster(1'b0);
      check("no_writes_when_idle", 32'(wr_seen - w0), 0);

      // Reset in the middle of a capture.
      arm = 1'b1; mode = 2'd0; idle(1); arm = 1'b0;
      sof(); sof();
      push(1, 'h123); pix(6, 3, 1'b1, 10'h123, 10'h0, 10'h0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_we",   32'(oMemWE), 0);
      check("rst_mid_addr", 32'(oMemAddr), 0);
      check("rst_mid_data", 32'(oMemData), 0);
      check("rst_mid_busy", 32'(oBusy), 0);
      check("rst_mid_stop", 32'(oStopCapture), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      w0 = wr_seen;
      pix(8, 3, 1'b1, 10'h0AB, 10'h0, 10'h0);
      sof();
      pix(4, 3, 1'b1, 10'h0CD, 10'h0, 10'h0);
      sof();
      pix(6, 5, 1'b1, 10'h0EF, 10'h0, 10'h0);
      check("no_writes_after_rst", 32'(wr_seen - w0), 0);
      check("idle_after_rst", 32'(oBusy), 0);
      idle(2);
      check("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_grabber.md
FRAME_GRABBER -- requirements
Module: frame_grabber

Interface
REQ-001 Parameter PIX_W, default 10, bits per input colour channel.
REQ-002 Parameter H_START, default 144, first captured column (iX units).
REQ-003 Parameter V_START, default 35, first captured row (iY units).
REQ-004 Parameter H_RES, default 160, window width in input pixels.
REQ-005 Parameter V_RES, default 120, window height in input pixels.
REQ-006 Parameter DECIM, default 1, power-of-two subsampling factor (1, 2 or 4) in both axes.
REQ-007 Parameter SKIP_FRAMES, default 300, frame starts counted after arm before capture begins.
REQ-008 Parameters SOF_X and SOF_Y, defaults 143 and 34, the coordinate that marks start of frame.
REQ-009 Parameter ADDR_W, default 15, memory address width; must satisfy 2^ADDR_W >= (H_RES/DECIM)*(V_RES/DECIM).
REQ-010 iCLK  in  1  pixel clock; all logic on rising edge.
REQ-011 iRST  in  1  asynchronous, active-high reset.
REQ-012 iRed, iGreen, iBlue  in  PIX_W each  pixel channels, qualified by iValid.
REQ-013 iX, iY  in  13 each  current pixel coordinates.
REQ-014 iValid  in  1  pixel and coordinates valid this cycle.
REQ-015 iArm  in  1  capture request, sampled per cycle.
REQ-016 iMode  in  2  source: 0 red, 1 green, 2 blue, 3 luma.
REQ-017 oMemAddr  out  ADDR_W  write address.
REQ-018 oMemData  out  PIX_W  write data.
REQ-019 oMemWE  out  1  write strobe, one cycle per stored pixel.
REQ-020 oBusy  out  1  high in any state except IDLE.
REQ-021 oStopCapture  out  1  high in CAPTURE only; upstream camera freezes on it.
REQ-022 oDone  out  1  one-cycle pulse when a frame is fully stored.

Function
REQ-023 FSM states SHALL be IDLE, SKIP, CAPTURE, DONE.
REQ-024 SOF SHALL be iValid && iX==SOF_X && iY==SOF_Y.
REQ-025 IDLE: iArm=1 SHALL latch iMode, clear the frame counter, go to SKIP; iArm in other states SHALL be ignored.
REQ-026 SKIP: each SOF SHALL increment a 16-bit frame counter; the SOF at which the counter reaches SKIP_FRAMES SHALL go to CAPTURE; with SKIP_FRAMES=0, the first SOF goes to CAPTURE.
REQ-027 In-window SHALL be H_START <= iX < H_START+H_RES and V_START <= iY < V_START+V_RES (upper bounds exclusive).
REQ-028 CAPTURE: a pixel SHALL be stored iff iValid, in-window, and (iX-H_START) and (iY-V_START) are both multiples of DECIM.
REQ-029 Address SHALL be ((iY-V_START)/DECIM)*(H_RES/DECIM) + (iX-H_START)/DECIM, truncated to ADDR_W.
REQ-030 Luma SHALL be (R + 2G + B) >> 2, computed at PIX_W+2 bits; result SHALL fit PIX_W without saturation.
REQ-031 oMemAddr, oMemData, oMemWE SHALL be registered, one cycle after the qualifying input.
REQ-032 oMemWE SHALL be 0 on every cycle without a qualifying pixel; address and data SHALL hold last values.
REQ-033 CAPTURE SHALL exit to DONE on the cycle the last address ((H_RES/DECIM)*(V_RES/DECIM)-1) is written, or at the next SOF if it never arrives.
REQ-034 DONE SHALL last exactly one cycle with oDone=1, then return to IDLE.
REQ-035 SOF coinciding with the last write SHALL be treated as completion (single DONE).

Reset
REQ-036 iRST SHALL immediately force IDLE, frame counter 0, oMemAddr 0, oMemData 0, oMemWE 0, oBusy 0, oStopCapture 0, oDone 0, latched mode 0.
REQ-037 Reset mid-CAPTURE SHALL abort without further writes; a new iArm is required.

Structure
REQ-038 State encoding, mode codes and SOF defaults SHALL reside in a shared package (frame_grabber_pkg).
REQ-039 Address/data generation SHALL be a sub-module, grab_pixel_path (window test, decimation, channel mux, luma, output registers); the FSM stays in frame_grabber.

Verification
REQ-040 SKIP_FRAMES=2, iArm, three SOFs -> CAPTURE entered at second SOF, oBusy high from cycle after iArm.
REQ-041 Mode 0, pixel (H_START,V_START) red=0x155 -> next cycle oMemWE=1, addr 0, data 0x155; pixel (H_START+H_RES,V_START) -> no write.
REQ-042 DECIM=2, pixel (H_START+3,V_START+2) -> no write; (H_START+4,V_START+2) -> addr H_RES/2+2.
REQ-043 Mode 3, R=0x3FF G=0x3FF B=0x3FF -> data 0x3FF; R=4 G=2 B=0 -> data 2.
REQ-044 Full raster -> exactly (H_RES/DECIM)*(V_RES/DECIM) writes, oDone single pulse, oStopCapture low after DONE.
REQ-045 iRST asserted mid-CAPTURE -> same-cycle outputs zero, IDLE; iArm during SKIP ignored.
